// File: rtl/swc_rtu_rsp_queue.sv
// Per-port FWFT queue of RTU forwarding decisions feeding the core's rtu_rsp handshake.
// Optional overflow counter is compiled in by defining SWC_RTU_RSP_OVF_CNT_EN.
module swc_rtu_rsp_queue #(
    parameter int g_num_ports  = 8,
    parameter int g_prio_width = 3,
    parameter int g_fifo_depth = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wr_i,
    input  logic [g_num_ports-1:0]            wr_mask_i,
    input  logic                              wr_drop_i,
    input  logic [g_prio_width-1:0]           wr_prio_i,
    output logic                              full_o,
    output logic                              rtu_rsp_valid_o,
    input  logic                              rtu_rsp_ack_i,
    output logic [g_num_ports-1:0]            rtu_dst_port_mask_o,
    output logic                              rtu_drop_o,
    output logic [g_prio_width-1:0]           rtu_prio_o,
    output logic [$clog2(g_fifo_depth):0]     level_o,
    output logic [15:0]                       ovf_cnt_o
);

    localparam int AW = $clog2(g_fifo_depth);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [g_num_ports-1:0]  mask;
        logic                    drop;
        logic [g_prio_width-1:0] prio;
    } entry_t;

    entry_t          mem_q [g_fifo_depth];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic            full;
    logic            valid;
    logic            push;
    logic            pop;
    entry_t          head;

    assign full  = (level_q == LW'(g_fifo_depth));
    assign valid = (level_q != '0);
    assign pop   = rtu_rsp_ack_i && valid;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign push  = wr_i && (!full || pop);

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < g_fifo_depth; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{mask: wr_mask_i, drop: wr_drop_i, prio: wr_prio_i};
        end
    end

    assign head                = mem_q[rd_ptr_q];
    assign rtu_dst_port_mask_o = head.mask;
    assign rtu_drop_o          = head.drop;
    assign rtu_prio_o          = head.prio;
    assign rtu_rsp_valid_o     = valid;
    assign full_o              = full;
    assign level_o             = level_q;

`ifdef SWC_RTU_RSP_OVF_CNT_EN
    logic        ovf;
    logic [15:0] ovf_cnt_q;
    logic [15:0] ovf_cnt_d;

    assign ovf = wr_i && full && !pop;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_swc_rtu_rsp_queue.sv
// Randomized self-checking bench for swc_rtu_rsp_queue against a queue-based model.
// Expected overflow count follows SWC_RTU_RSP_OVF_CNT_EN.
module tb_swc_rtu_rsp_queue;

`ifdef SWC_RTU_RSP_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [7:0]  mask;
    logic        drop;
    logic [2:0]  prio;
    logic        ack;
    logic        full;
    logic        valid;
    logic [7:0]  hmask;
    logic        hdrop;
    logic [2:0]  hprio;
    logic [2:0]  level;
    logic [15:0] ovf;

    typedef struct {
        logic [7:0] m;
        logic       d;
        logic [2:0] p;
    } ent_t;

    ent_t mq[$];
    int   movf;
    int   vectors;
    int   errors;

    swc_rtu_rsp_queue dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .wr_i                (wr),
        .wr_mask_i           (mask),
        .wr_drop_i           (drop),
        .wr_prio_i           (prio),
        .full_o              (full),
        .rtu_rsp_valid_o     (valid),
        .rtu_rsp_ack_i       (ack),
        .rtu_dst_port_mask_o (hmask),
        .rtu_drop_o          (hdrop),
        .rtu_prio_o          (hprio),
        .level_o             (level),
        .ovf_cnt_o           (ovf)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model on the edge, return #1 after it.
    task automatic step(input logic w, input logic [7:0] m, input logic d,
                        input logic [2:0] p, input logic a);
        bit was_valid;
        bit was_full;
        bit popped;
        @(negedge clk);
        wr = w; mask = m; drop = d; prio = p; ack = a;
        @(posedge clk);
        was_valid = (mq.size() != 0);
        was_full  = (mq.size() == DEPTH);
        popped    = a && was_valid;
        if (popped) void'(mq.pop_front());
        if (w && (!was_full || popped)) mq.push_back('{m, d, p});
        else if (w && OVF_EN && movf < 65535) movf++;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr = 0; mask = 0; drop = 0; prio = 0; ack = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({valid, full, level, ovf} !== 21'd0) begin
            errors++;
            $display("FAIL reset_status: valid=%b full=%b level=%0d ovf=%0d want 0",
                     valid, full, level, ovf);
        end
        vectors++;
        if ({hmask, hdrop, hprio} !== 12'd0) begin
            errors++;
            $display("FAIL reset_head: got %h/%b/%0d want 0", hmask, hdrop, hprio);
        end
        @(negedge clk) rst = 1'b0;
        mq.delete(); movf = 0;
    endtask

    task automatic test_single;
        step(1, 8'h05, 0, 3'd3, 0);
        vectors++;
        if (valid !== 1'b1 || hmask !== 8'h05 || hprio !== 3'd3 || hdrop !== 1'b0
            || level !== 3'd1) begin
            errors++;
            $display("FAIL single_write: v=%b m=%h p=%0d d=%b lvl=%0d want 1/05/3/0/1",
                     valid, hmask, hprio, hdrop, level);
        end
        step(0, 0, 0, 0, 1);
        vectors++;
        if (valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL single_ack: v=%b lvl=%0d want 0/0", valid, level);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_m;
        for (int i = 0; i < 4; i++)
            step(1, 8'(1 << i), 1'($urandom), 3'($urandom), 0);
        vectors++;
        if (full !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: full=%b lvl=%0d want 1/4", full, level);
        end
        step(1, 8'h10, 0, 0, 0);
        vectors++;
        if (ovf !== (OVF_EN ? 16'd1 : 16'd0) || level !== 3'd4 || hmask !== 8'h01) begin
            errors++;
            $display("FAIL overflow: ovf=%0d lvl=%0d head=%h want %0d/4/01",
                     ovf, level, hmask, OVF_EN ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_m = 8'(1 << i);
            vectors++;
            if (valid !== 1'b1 || hmask !== exp_m || hdrop !== mq[0].d || hprio !== mq[0].p) begin
                errors++;
                $display("FAIL drain_order[%0d]: v=%b m=%h d=%b p=%0d want 1/%h/%b/%0d",
                         i, valid, hmask, hdrop, hprio, exp_m, mq[0].d, mq[0].p);
            end
            step(0, 0, 0, 0, 1);
        end
        vectors++;
        if (valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: v=%b lvl=%0d want 0/0", valid, level);
        end
    endtask

    task automatic test_full_write_ack;
        for (int i = 0; i < 4; i++)
            step(1, 8'($urandom_range(1, 127)), 1'($urandom), 3'($urandom), 0);
        step(1, 8'h80, 1, 3'd7, 1);
        vectors++;
        if (level !== 3'd4 || full !== 1'b1 || ovf !== 16'(movf)) begin
            errors++;
            $display("FAIL full_wr_ack: lvl=%0d full=%b ovf=%0d want 4/1/%0d",
                     level, full, ovf, movf);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (valid !== 1'b1 || hmask !== mq[0].m || hdrop !== mq[0].d || hprio !== mq[0].p) begin
                errors++;
                $display("FAIL full_drain[%0d]: m=%h d=%b p=%0d want %h/%b/%0d",
                         i, hmask, hdrop, hprio, mq[0].m, mq[0].d, mq[0].p);
            end
            if (i == 3) begin
                vectors++;
                if (hmask !== 8'h80) begin
                    errors++;
                    $display("FAIL last_out: got %h want 80", hmask);
                end
            end
            step(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] prev;
        int         ovf0;
        ovf0 = movf;
        prev = 8'h20;
        step(1, prev, 0, 3'd1, 0);
        for (int i = 1; i <= 20; i++) begin
            step(1, 8'(8'h20 + i), 1'(i), 3'(i), 1);
            vectors++;
            if (level !== 3'd1 || valid !== 1'b1 || hmask !== 8'(8'h20 + i)
                || hprio !== 3'(i) || ovf !== 16'(ovf0)) begin
                errors++;
                $display("FAIL stream[%0d]: lvl=%0d m=%h p=%0d ovf=%0d want 1/%h/%0d/%0d",
                         i, level, hmask, hprio, ovf, 8'(8'h20 + i), 3'(i), ovf0);
            end
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_empty_ack;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'($urandom), 0, 0, 1);
            vectors++;
            if (valid !== 1'b0 || level !== 3'd0 || full !== 1'b0) begin
                errors++;
                $display("FAIL empty_ack[%0d]: v=%b lvl=%0d full=%b want 0/0/0",
                         i, valid, level, full);
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++)
            step(1, 8'($urandom_range(1, 255)), 0, 3'($urandom), 0);
        step(0, 0, 0, 0, 0);
        vectors++;
        if (level !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset_level: got %0d want 3", level);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (valid !== 1'b0 || full !== 1'b0 || level !== 3'd0 || ovf !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: v=%b full=%b lvl=%0d ovf=%0d want 0",
                     valid, full, level, ovf);
        end
        mq.delete(); movf = 0;
        @(negedge clk) rst = 1'b0;
        step(1, 8'hA5, 1, 3'd6, 0);
        vectors++;
        if (valid !== 1'b1 || hmask !== 8'hA5 || hdrop !== 1'b1 || hprio !== 3'd6
            || level !== 3'd1) begin
            errors++;
            $display("FAIL post_reset: v=%b m=%h d=%b p=%0d lvl=%0d want 1/a5/1/6/1",
                     valid, hmask, hdrop, hprio, level);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom),
                 3'($urandom), 1'($urandom_range(0, 99) < 45));
            vectors++;
            if (valid !== (mq.size() != 0) || level !== 3'(mq.size())
                || full !== (mq.size() == DEPTH) || ovf !== 16'(movf)) begin
                errors++;
                $display("FAIL rand_status[%0d]: v=%b lvl=%0d full=%b ovf=%0d want lvl=%0d ovf=%0d",
                         i, valid, level, full, ovf, mq.size(), movf);
            end
            if (mq.size() != 0) begin
                vectors++;
                if (hmask !== mq[0].m || hdrop !== mq[0].d || hprio !== mq[0].p) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: %h/%b/%0d want %h/%b/%0d",
                             i, hmask, hdrop, hprio, mq[0].m, mq[0].d, mq[0].p);
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        movf    = 0;
        test_reset();
        test_single();
        test_overflow();
        test_full_write_ack();
        test_back_to_back();
        test_empty_ack();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/swc_rtu_rsp_queue.md
# swc_rtu_rsp_queue

Per-port buffer for RTU forwarding decisions, upstream of the switching core's `rtu_rsp_*` interface. It accepts decisions (destination mask, drop flag, priority) from the routing table unit as single-cycle write strobes. It holds them in a small FIFO and presents the oldest one to the core through a valid/ack handshake. This keeps bursts of RTU answers from stalling the RTU while the core's input block is still busy with an earlier frame. One instance is built per switch port; the per-port outputs are concatenated into the core's flat `rtu_*` vectors.

## Interface
- `g_num_ports`, default 8: width of the destination port mask.
- `g_prio_width`, default 3: priority field width.
- `g_fifo_depth`, default 4: number of entries; must be a power of two, at least 2.

Ports:
- `clk_i`  in  1  system clock; all logic is on its rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- `wr_i`  in  1  write strobe from RTU, one entry per cycle high.
- `wr_mask_i`  in  `g_num_ports`  destination port mask.
- `wr_drop_i`  in  1  drop decision.
- `wr_prio_i`  in  `g_prio_width`  priority.
- `full_o`  out  1  queue holds `g_fifo_depth` entries.
- `rtu_rsp_valid_o`  out  1  head entry valid.
- `rtu_rsp_ack_i`  in  1  core consumed the head entry.
- `rtu_dst_port_mask_o`  out  `g_num_ports`  head mask.
- `rtu_drop_o`  out  1  head drop flag.
- `rtu_prio_o`  out  `g_prio_width`  head priority.
- `level_o`  out  clog2(`g_fifo_depth`)+1  current occupancy.
- `ovf_cnt_o`  out  16  count of discarded writes.

## Operation
- Storage is a circular buffer with read and write pointers, each clog2(depth) bits and wrapping naturally.
- An occupancy counter `level` runs from 0 to depth.
- `full_o` = (level == depth). `rtu_rsp_valid_o` = (level != 0).
- Head outputs are read directly from the entry at the read pointer (first-word fall-through). Their contents are don't-care while valid is low, but must be stable while valid is high and no ack has occurred.
- Push: `wr_i` high and (not full, or `rtu_rsp_ack_i` high with valid). The entry is written at the write pointer, which then increments.
- Pop: `rtu_rsp_ack_i` high and valid high. The read pointer increments. An ack while valid is low is ignored and has no effect.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Write while full with no ack: the entry is discarded, no state changes, and an overflow event is raised.
- Entry with an all-zero mask and drop low: stored as-is. The queue does not interpret the contents.
- Reset at any time, including mid-burst: pointers = 0, level = 0, ovf count = 0, and all in-flight entries are lost.
- Reset values: `rtu_rsp_valid_o`=0, `full_o`=0, `level_o`=0, `ovf_cnt_o`=0. Head data outputs are 0, because the storage array resets to 0.

## Timing
- Write latency: `wr_i` in cycle N makes the entry visible, and valid high, in cycle N+1 if the queue was empty.
- Ack in cycle N: the next entry, or valid=0, appears in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- `full_o` and `level_o` are registered. They reflect state after the previous edge.
- A write that arrives with `full_o` high is only safe when an ack is issued in the same cycle.
- `ovf_cnt_o` updates one cycle after the overflow event.
- `ovf_cnt_o` saturates at 0xFFFF; it does not wrap.

## Configuration
- `SWC_RTU_RSP_OVF_CNT_EN` defined: 16-bit saturating overflow counter compiled in and driven to `ovf_cnt_o`.
- Not defined: no counter register. `ovf_cnt_o` is tied to 0, and overflowing writes are still silently discarded.

## Test plan
- Reset, then single write (mask=0x05, drop=0, prio=3) -> valid high next cycle with mask 0x05, prio 3; ack -> valid low next cycle, level 0.
- Four back-to-back writes (masks 0x01, 0x02, 0x04, 0x08) with no ack -> `full_o`=1, level 4. A fifth write (0x10) -> discarded, ovf_cnt 1 when the macro is defined, otherwise 0. Four acks -> masks 0x01, 0x02, 0x04, 0x08 in order.
- Full queue, write 0x80 together with ack -> level stays 4; after draining, 0x80 is the last entry out.
- Continuous write plus ack every cycle for 20 cycles with incrementing masks -> level constant at 1, outputs in order, no overflow; pointer wrap exercised.
- Ack pulses with the queue empty -> no state change, level 0, valid 0.
- Three entries queued, `rst_i` asserted mid-cycle (asynchronous) -> valid, full, and level drop to 0 immediately. After release, the first new write is the next entry out.
